scnn_decompression_wts: RTL and testbench



---
 rtl/scnn_decompression_wts.sv | 123 ++++++++++++
 tb/tb_scnn_decompression_wts.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scnn_decompression_wts.sv
// Sequential SCNN weight decompressor: scatters a zero-run encoded 5x5 filter
// tile into a dense N-entry buffer, one nonzero per clock.
module scnn_decompression_wts #(
  parameter int N  = 25,
  parameter int DW = 16,
  parameter int IW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] comp_arr,
  input  logic [N*IW-1:0] comp_ind,
  input  logic [IW-1:0]   non_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] dense_arr,
  output logic            err
);

  localparam int AW = $clog2(N);
  localparam logic [IW-1:0] N_IW     = IW'(N);
  localparam logic [IW-1:0] ONE      = IW'(1);
  localparam logic [IW:0]   LAST_IDX = (IW+1)'(N-1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

  state_t          state;
  logic [N*DW-1:0] val_q;
  logic [N*IW-1:0] ind_q;
  logic [IW-1:0]   nz_q;
  logic [IW-1:0]   pos;
  logic [IW-1:0]   k;

  logic [AW-1:0]   k_idx;
  logic [AW-1:0]   t_idx;
  logic [IW-1:0]   cur_ind;
  logic [DW-1:0]   cur_val;
  logic [IW:0]     target;

  // Target is one bit wider than the indices so a run past the tile end is caught, not wrapped.
  always_comb begin
    k_idx   = k[AW-1:0];
    cur_ind = ind_q[k_idx*IW +: IW];
    cur_val = val_q[k_idx*DW +: DW];
    target  = {1'b0, pos} + {1'b0, cur_ind};
    t_idx   = target[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dense_arr <= '0;
      err       <= 1'b0;
      val_q     <= '0;
      ind_q     <= '0;
      nz_q      <= '0;
      pos       <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            val_q     <= comp_arr;
            ind_q     <= comp_ind;
            nz_q      <= non_zero;
            dense_arr <= '0;
            err       <= 1'b0;
            pos       <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            if (non_zero == '0) begin
              state <= DONE;
            end else if (non_zero > N_IW) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= DECODE;
            end
          end
        end

        DECODE: begin
          if (target > LAST_IDX) begin
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dense_arr[t_idx*DW +: DW] <= cur_val;
            pos <= target[IW-1:0] + ONE;
            k   <= k + ONE;
            if (k == nz_q - ONE) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        // Empty and oversized tiles arrive here straight from IDLE and raise out_valid one cycle later.
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scnn_decompression_wts.sv
// Self-checking bench for scnn_decompression_wts: directed corner tiles plus
// randomized compressor round-trips and malformed tiles against a reference model.
module tb_scnn_decompression_wts;

  localparam int N  = 25;
  localparam int DW = 16;
  localparam int IW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] comp_arr;
  logic [N*IW-1:0] comp_ind;
  logic [IW-1:0]   non_zero;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] dense_arr;
  logic            err;

  int checks = 0;
  int errors = 0;

  scnn_decompression_wts #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comp_arr  (comp_arr),
    .comp_ind  (comp_ind),
    .non_zero  (non_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dense_arr (dense_arr),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] randVals();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [N*IW-1:0] randInds();
    logic [N*IW-1:0] v;
    for (int i = 0; i < N; i++) v[i*IW +: IW] = IW'($urandom);
    return v;
  endfunction

  // Reference: walk the zero-run list, stop on the first entry that lands past the tile.
  function automatic void model(input int nz, input logic [N*DW-1:0] vals, input logic [N*IW-1:0] inds,
                                output logic [N*DW-1:0] d, output logic e, output int lat);
    int pos;
    int t;
    d   = '0;
    e   = 1'b0;
    pos = 0;
    if (nz == 0) begin
      lat = 1;
    end else if (nz > N) begin
      e   = 1'b1;
      lat = 1;
    end else begin
      lat = nz;
      for (int j = 0; j < nz; j++) begin
        t = pos + int'(inds[j*IW +: IW]);
        if (t > N - 1) begin
          e   = 1'b1;
          lat = j + 1;
          break;
        end
        d[t*DW +: DW] = vals[j*DW +: DW];
        pos = t + 1;
      end
    end
  endfunction

  // Weight compressor: unused slots are left as random garbage.
  function automatic void compress(input logic [N*DW-1:0] d, output logic [N*DW-1:0] v,
                                   output logic [N*IW-1:0] ix, output int nz);
    int run;
    v   = randVals();
    ix  = randInds();
    nz  = 0;
    run = 0;
    for (int i = 0; i < N; i++) begin
      if (d[i*DW +: DW] != '0) begin
        v[nz*DW +: DW]  = d[i*DW +: DW];
        ix[nz*IW +: IW] = IW'(run);
        nz++;
        run = 0;
      end else begin
        run++;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [IW-1:0] nz, input logic [N*DW-1:0] vals,
                               input logic [N*IW-1:0] inds, input int hold,
                               output logic [N*DW-1:0] got);
    logic [N*DW-1:0] expd;
    logic            expe;
    int              explat;
    int              lat;
    int              guard;
    model(int'(nz), vals, inds, expd, expe, explat);
    @(negedge clk);
    comp_arr  = vals;
    comp_ind  = inds;
    non_zero  = nz;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_wait", guard < 64, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    comp_arr = randVals();
    comp_ind = randInds();
    non_zero = IW'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, explat);
    checkOutput("dense", dense_arr, expd);
    checkOutput("err", err, expe);
    checkOutput("busy_ready", in_ready, 1'b0);
    got = dense_arr;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      comp_arr = ~vals;
      comp_ind = '0;
      non_zero = 8'd5;
      @(negedge clk);
      checkOutput("bp_dense", dense_arr, expd);
      checkOutput("bp_err", err, expe);
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("valid_drop", out_valid, 1'b0);
    checkOutput("ready_back", in_ready, 1'b1);
    checkOutput("dense_keep", dense_arr, expd);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [N*DW-1:0] vals;
    logic [N*IW-1:0] inds;
    logic [N*DW-1:0] got;
    logic [N*DW-1:0] lit;
    logic [N*DW-1:0] orig;
    int              nz;
    int              density;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    comp_arr  = '0;
    comp_ind  = '0;
    non_zero  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_dense", dense_arr, '0);
    checkOutput("rst_err", err, 1'b0);

    $display("[TB] sparse tile");
    vals = randVals();
    inds = randInds();
    vals[0 +: DW] = 16'h0011; vals[DW +: DW] = 16'h0022; vals[2*DW +: DW] = 16'h0033;
    inds[0 +: IW] = 8'd2;     inds[IW +: IW] = 8'd0;     inds[2*IW +: IW] = 8'd5;
    lit = '0;
    lit[2*DW +: DW] = 16'h0011; lit[3*DW +: DW] = 16'h0022; lit[9*DW +: DW] = 16'h0033;
    applyStimulus(8'd3, vals, inds, 0, got);
    checkOutput("sparse_lit", got, lit);

    $display("[TB] full and empty tiles");
    lit = '0;
    for (int i = 0; i < N; i++) begin
      vals[i*DW +: DW] = DW'(i + 1);
      lit[i*DW +: DW]  = DW'(i + 1);
    end
    applyStimulus(8'd25, vals, '0, 0, got);
    checkOutput("full_lit", got, lit);
    applyStimulus(8'd0, randVals(), randInds(), 0, got);
    checkOutput("empty_lit", got, '0);

    $display("[TB] overflow tiles");
    vals = randVals();
    inds = randInds();
    inds[0 +: IW] = 8'd20;
    inds[IW +: IW] = 8'd10;
    lit = '0;
    lit[20*DW +: DW] = vals[0 +: DW];
    applyStimulus(8'd2, vals, inds, 0, got);
    checkOutput("ovf_lit", got, lit);
    applyStimulus(8'd30, randVals(), '0, 0, got);
    checkOutput("too_many_lit", got, '0);

    $display("[TB] backpressure");
    applyStimulus(8'd4, randVals(), {N{8'd1}}, 5, got);
    applyStimulus(8'd2, randVals(), {N{8'd3}}, 0, got);

    $display("[TB] reset during decode");
    @(negedge clk);
    for (int i = 0; i < N; i++) vals[i*DW +: DW] = DW'(16'h0100 + i);
    comp_arr = vals;
    comp_ind = {N{8'd1}};
    non_zero = 8'd10;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_dense", dense_arr, '0);
    checkOutput("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    inds = randInds();
    inds[0 +: IW] = 8'd0; inds[IW +: IW] = 8'd1; inds[2*IW +: IW] = 8'd0;
    vals = randVals();
    lit = '0;
    lit[0 +: DW] = vals[0 +: DW]; lit[2*DW +: DW] = vals[DW +: DW]; lit[3*DW +: DW] = vals[2*DW +: DW];
    applyStimulus(8'd3, vals, inds, 0, got);
    checkOutput("post_rst_lit", got, lit);

    $display("[TB] compressor round-trips");
    for (int t = 0; t < 30; t++) begin
      density = $urandom_range(0, 100);
      orig = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < density) orig[i*DW +: DW] = DW'($urandom_range(1, 65535));
      compress(orig, vals, inds, nz);
      applyStimulus(IW'(nz), vals, inds, $urandom_range(0, 2), got);
      checkOutput("roundtrip", got, orig);
    end

    $display("[TB] random malformed tiles");
    for (int t = 0; t < 20; t++) begin
      vals = randVals();
      for (int i = 0; i < N; i++)
        inds[i*IW +: IW] = ($urandom_range(0, 7) == 0) ? IW'($urandom) : IW'($urandom_range(0, 2));
      applyStimulus(IW'($urandom_range(0, 30)), vals, inds, 0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
